// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
//   state_e : access sequencer states
//   owner_t : which requester owns the access in flight
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  typedef logic owner_t;

  localparam owner_t OwnIf = 1'b0;
  localparam owner_t OwnDm = 1'b1;

endpackage

// File: rtl/mem_arb_fairness.sv
// Winner selection with a bounded data-priority streak.
//   clk_i, rst_ni : clock, async active-low reset
//   if_req_i      : fetch request
//   dm_req_i      : data request
//   grant_i       : an arbitration decision is taken this cycle
//   winner_o      : OwnIf / OwnDm, valid whenever a request is present
module mem_arb_fairness
  import mem_arb_pkg::*;
#(
  parameter int unsigned MaxDataBurst = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   if_req_i,
  input  logic   dm_req_i,
  input  logic   grant_i,
  output owner_t winner_o
);

  localparam int unsigned StreakW = $clog2(MaxDataBurst + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MaxDataBurst);

  logic [StreakW-1:0] streak_q, streak_d;
  logic               starved;

  // Data wins by default; a waiting fetch takes over once the streak saturates.
  assign starved  = if_req_i && (streak_q == StreakMax);
  assign winner_o = (if_req_i && (starved || !dm_req_i)) ? OwnIf : OwnDm;

  always_comb begin
    streak_d = streak_q;
    if (grant_i) begin
      // Streak only counts data grants that actually made a fetch wait.
      if ((winner_o == OwnIf) || !if_req_i) begin
        streak_d = '0;
      end else if (streak_q != StreakMax) begin
        streak_d = streak_q + StreakW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch and
// data access. One access in flight at a time; data has priority, bounded by
// the fairness streak.
//   clk, reset       : clock, async active-low reset
//   if_req/if_addr   : fetch request (held until if_valid)
//   if_rdata/if_valid: registered fetch data and one-cycle completion pulse
//   if_stall         : if_req & ~if_valid
//   dm_*             : data request/response, same handshake as fetch
//   mem_*            : memory macro interface, mem_rdata valid MEM_LAT after mem_en
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MEM_LAT        = 2,
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned LatW = $clog2(MEM_LAT + 1);

  state_e            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              store_q, store_d;
  logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;
  owner_t            winner;
  logic              grant;
  logic              issue;
  logic              last_wait;

  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, dm_rdata_d;
  logic              if_valid_d, dm_valid_d;

  assign grant     = (state_q == StIdle) && (if_req || dm_req);
  assign issue     = (state_d == StIssue);
  // Final WAIT cycle: memory data is on mem_rdata right now.
  assign last_wait = (state_q == StWait) && (lat_cnt_q == LatW'(1));

  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

  mem_arb_fairness #(
    .MaxDataBurst(MAX_DATA_BURST)
  ) u_fairness (
    .clk_i   (clk),
    .rst_ni  (reset),
    .if_req_i(if_req),
    .dm_req_i(dm_req),
    .grant_i (grant),
    .winner_o(winner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      owner_q   <= OwnIf;
      store_q   <= 1'b0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      store_q   <= store_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    store_d   = store_q;
    lat_cnt_d = lat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          owner_d = winner;
          // Latch the direction so a misbehaving requester cannot change it mid-access.
          store_d = (winner == OwnDm) && dm_we;
          state_d = StIssue;
        end
      end
      StIssue: begin
        lat_cnt_d = LatW'(MEM_LAT);
        state_d   = StWait;
      end
      StWait: begin
        lat_cnt_d = lat_cnt_q - LatW'(1);
        if (last_wait) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are computed from the next state so they appear registered in the
  // cycle the FSM enters the matching state.
  always_comb begin
    mem_en_d    = issue;
    mem_we_d    = issue && (owner_d == OwnDm) && store_d;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if (issue) begin
      mem_addr_d = (owner_d == OwnDm) ? dm_addr : if_addr;
      if (owner_d == OwnDm) begin
        mem_wdata_d = dm_wdata;
      end
    end
    if_rdata_d = (last_wait && (owner_q == OwnIf)) ? mem_rdata : if_rdata;
    dm_rdata_d = (last_wait && (owner_q == OwnDm) && !store_q) ? mem_rdata : dm_rdata;
    if_valid_d = (state_d == StResp) && (owner_q == OwnIf);
    dm_valid_d = (state_d == StResp) && (owner_q == OwnDm);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
    end else begin
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
      if_valid  <= if_valid_d;
      dm_valid  <= dm_valid_d;
    end
  end

endmodule
